// File: rtl/vericlock_pkg.sv
// rtl/vericlock_pkg.sv - shared digit, blink and segment-field definitions for the vericlock display path
package vericlock_pkg;

   // Digit positions in scan order.
   localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
   localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
   localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
   localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
   localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
   localparam logic [2:0] DIG_HOUR_TENS = 3'd5;
   localparam int         NUM_DIGITS    = 6;

   // Field selected for blinking while the clock is being set.
   localparam logic [1:0] BLINK_NONE = 2'd0;
   localparam logic [1:0] BLINK_SEC  = 2'd1;
   localparam logic [1:0] BLINK_MIN  = 2'd2;
   localparam logic [1:0] BLINK_HOUR = 2'd3;

   // Each 14-bit field is {tens, ones}, each half {g,f,e,d,c,b,a}.
   localparam int SEG_W        = 7;
   localparam int SEG_ONES_LSB = 0;
   localparam int SEG_TENS_LSB = 7;
   localparam int FIELD_W      = 14;

   typedef struct packed {
      logic [FIELD_W-1:0] hour;
      logic [FIELD_W-1:0] min;
      logic [FIELD_W-1:0] sec;
   } snapshot_t;

   // Segment pattern for one digit position of a captured frame.
   function automatic logic [SEG_W-1:0] digit_pattern(input snapshot_t s, input logic [2:0] idx);
      logic [SEG_W-1:0] p;
      case (idx)
         DIG_SEC_ONES:  p = s.sec[SEG_ONES_LSB +: SEG_W];
         DIG_SEC_TENS:  p = s.sec[SEG_TENS_LSB +: SEG_W];
         DIG_MIN_ONES:  p = s.min[SEG_ONES_LSB +: SEG_W];
         DIG_MIN_TENS:  p = s.min[SEG_TENS_LSB +: SEG_W];
         DIG_HOUR_ONES: p = s.hour[SEG_ONES_LSB +: SEG_W];
         DIG_HOUR_TENS: p = s.hour[SEG_TENS_LSB +: SEG_W];
         default:       p = '0;
      endcase
      return p;
   endfunction

   // True when the digit belongs to the field chosen by blink_sel.
   function automatic logic in_blink_field(input logic [2:0] idx, input logic [1:0] sel);
      logic r;
      case (sel)
         BLINK_SEC:  r = (idx == DIG_SEC_ONES)  || (idx == DIG_SEC_TENS);
         BLINK_MIN:  r = (idx == DIG_MIN_ONES)  || (idx == DIG_MIN_TENS);
         BLINK_HOUR: r = (idx == DIG_HOUR_ONES) || (idx == DIG_HOUR_TENS);
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/vericlock_tick_div.sv
// rtl/vericlock_tick_div.sv - free-running modulo counter with a wrap pulse
module vericlock_tick_div #(
   parameter int TERMINAL = 10,
   parameter int W        = (TERMINAL > 1) ? $clog2(TERMINAL) : 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   if (TERMINAL < 1) begin : g_bad_terminal
      $error("vericlock_tick_div: TERMINAL must be at least 1");
   end

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap_o = (cnt_q == W'(TERMINAL - 1));
   assign cnt_o  = cnt_q;

   // Count up, returning to zero on the last cycle of the period.
   always_comb begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
   end

   // Counter state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vericlock_7seg_scan.sv
// rtl/vericlock_7seg_scan.sv - six-digit multiplexed 7-segment scanner with blanking, snapshot and blink
module vericlock_7seg_scan
   import vericlock_pkg::*;
#(
   parameter int CLK_HZ         = 100_000_000,
   parameter int REFRESH_HZ     = 1000,
   parameter int BLANK_CYCLES   = 100,
   parameter int BLINK_HZ       = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        enable,
   input  logic [13:0] sec_7seg,
   input  logic [13:0] min_7seg,
   input  logic [13:0] hour_7seg,
   input  logic [1:0]  blink_sel,
   input  logic        dp_en,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [5:0]  an,
   output logic        frame_tick
);

   localparam int DIGIT_CYCLES = CLK_HZ / REFRESH_HZ;
   localparam int BLINK_CYCLES = CLK_HZ / (2 * BLINK_HZ);
   localparam int SLOT_W       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int BLINK_W      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   // Inactive levels of the pins, so reset and blanking share one definition.
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [5:0] AN_OFF  = (AN_ACTIVE_LOW != 0)  ? 6'h3F : 6'h00;

   if (DIGIT_CYCLES <= BLANK_CYCLES) begin : g_bad_blank
      $error("vericlock_7seg_scan: DIGIT_CYCLES must exceed BLANK_CYCLES");
   end

   logic [SLOT_W-1:0]  slot_cnt;
   logic               slot_wrap;
   logic [BLINK_W-1:0] blink_cnt_unused;  // only the wrap matters for the phase
   logic               blink_wrap;

   logic [2:0]  dig_q, dig_d;
   logic        phase_q, phase_d;
   snapshot_t   snap_q, snap_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic [5:0]  an_q, an_d;
   logic        frame_tick_q, frame_tick_d;

   logic        frame_start;
   logic        blank;
   logic        suppress;
   logic        lit;
   logic [5:0]  an_lit;
   logic [6:0]  seg_lit;
   logic        dp_lit;

   vericlock_tick_div #(
      .TERMINAL (DIGIT_CYCLES),
      .W        (SLOT_W)
   ) u_slot_div (
      .clk_i  (clk_100MHz),
      .rst_i  (reset),
      .cnt_o  (slot_cnt),
      .wrap_o (slot_wrap)
   );

   vericlock_tick_div #(
      .TERMINAL (BLINK_CYCLES),
      .W        (BLINK_W)
   ) u_blink_div (
      .clk_i  (clk_100MHz),
      .rst_i  (reset),
      .cnt_o  (blink_cnt_unused),
      .wrap_o (blink_wrap)
   );

   // Scan position, blink phase and frame snapshot next-state.
   always_comb begin
      dig_d = dig_q;
      if (slot_wrap) begin
         dig_d = (dig_q == DIG_HOUR_TENS) ? DIG_SEC_ONES : dig_q + 3'd1;
      end
      phase_d     = phase_q ^ blink_wrap;
      frame_start = (slot_cnt == '0) && (dig_q == DIG_SEC_ONES);
      snap_d      = frame_start ? {hour_7seg, min_7seg, sec_7seg} : snap_q;
   end

   // Pin values for the current scan state; the captured frame feeds the segments so a
   // frame-start slot with no blanking still shows the new frame.
   always_comb begin
      blank        = (slot_cnt < SLOT_W'(BLANK_CYCLES));
      suppress     = phase_q && in_blink_field(dig_q, blink_sel);
      lit          = !blank && !suppress;
      an_lit       = (enable && lit) ? (6'(1) << dig_q) : 6'h00;
      seg_lit      = lit ? digit_pattern(snap_d, dig_q) : 7'h00;
      dp_lit       = dp_en && lit && ((dig_q == DIG_MIN_ONES) || (dig_q == DIG_HOUR_ONES));
      an_d         = (AN_ACTIVE_LOW != 0)  ? ~an_lit  : an_lit;
      seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
      dp_d         = (SEG_ACTIVE_LOW != 0) ? ~dp_lit  : dp_lit;
      frame_tick_d = frame_start;
   end

   // Scan state and registered outputs.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         dig_q        <= DIG_SEC_ONES;
         phase_q      <= 1'b0;
         snap_q       <= '0;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         an_q         <= AN_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         dig_q        <= dig_d;
         phase_q      <= phase_d;
         snap_q       <= snap_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vericlock_7seg_scan.sv
// tb/tb_vericlock_7seg_scan.sv - randomized self-checking bench for vericlock_7seg_scan
module tb_vericlock_7seg_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic [13:0] sec_7seg = '0;
   logic [13:0] min_7seg = '0;
   logic [13:0] hour_7seg = '0;
   logic [1:0]  blink_sel = 2'd0;
   logic        dp_en = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [5:0]  an;
   logic        frame_tick;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: cycles since reset release and the frame it captured.
   int          c = 0;
   logic [13:0] snap_sec = '0;
   logic [13:0] snap_min = '0;
   logic [13:0] snap_hour = '0;
   logic [5:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_ft;

   vericlock_7seg_scan #(
      .CLK_HZ         (1000),
      .REFRESH_HZ     (100),
      .BLANK_CYCLES   (2),
      .BLINK_HZ       (25),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk_100MHz (clk),
      .reset      (rst),
      .enable     (enable),
      .sec_7seg   (sec_7seg),
      .min_7seg   (min_7seg),
      .hour_7seg  (hour_7seg),
      .blink_sel  (blink_sel),
      .dp_en      (dp_en),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Expected pins for cycle c derived from plain arithmetic on time, then one clock.
   task automatic tick();
      int slot, dig, phase;
      logic blank, sup;
      logic [13:0] f;
      logic [6:0] pat;
      if (c % 60 == 0) begin
         snap_sec  = sec_7seg;
         snap_min  = min_7seg;
         snap_hour = hour_7seg;
      end
      slot  = c % 10;
      dig   = (c / 10) % 6;
      phase = (c / 20) % 2;
      blank = (slot < 2);
      sup   = (phase == 1) && (blink_sel != 2'd0) && (int'(blink_sel) == dig / 2 + 1);
      f     = (dig / 2 == 0) ? snap_sec : (dig / 2 == 1) ? snap_min : snap_hour;
      pat   = (dig % 2 == 0) ? f[6:0] : f[13:7];
      e_an  = (enable && !blank && !sup) ? ~(6'd1 << dig) : 6'h3F;
      e_seg = (!blank && !sup) ? ~pat : 7'h7F;
      e_dp  = (dp_en && !blank && !sup && (dig == 2 || dig == 4)) ? 1'b0 : 1'b1;
      e_ft  = (c % 60 == 0);
      @(posedge clk);
      c++;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
      c = 0;
      snap_sec = '0;
      snap_min = '0;
      snap_hour = '0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [5:0] seq [14];
      seq = '{6'h3F, 6'h3F, 6'h3F, 6'h3E, 6'h3E, 6'h3E, 6'h3E, 6'h3E,
              6'h3E, 6'h3E, 6'h3E, 6'h3F, 6'h3F, 6'h3D};
      enable = 1'b1; blink_sel = 2'd0; dp_en = 1'b1;
      sec_7seg = 14'($urandom); min_7seg = 14'($urandom); hour_7seg = 14'($urandom);
      do_reset(5);
      vectors++; if (an !== 6'h3F) begin miscompares++; $display("FAIL reset_an got %h exp 3f", an); end
      vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg got %h exp 7f", seg); end
      vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp got %b exp 1", dp); end
      vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_ft got %b exp 0", frame_tick); end
      for (int i = 1; i < 14; i++) begin
         tick();
         vectors++;
         if (an !== seq[i]) begin miscompares++; $display("FAIL scan_seq[%0d] an got %h exp %h", i, an, seq[i]); end
      end
      repeat (130) begin
         tick();
         vectors++; if (an !== e_an) begin miscompares++; $display("FAIL scan_an c=%0d got %h exp %h", c - 1, an, e_an); end
         vectors++; if (frame_tick !== e_ft) begin miscompares++; $display("FAIL scan_ft c=%0d got %b exp %b", c - 1, frame_tick, e_ft); end
      end
   endtask

   task automatic test_digit_content();
      int cur;
      enable = 1'b1; blink_sel = 2'd0; dp_en = 1'b0;
      sec_7seg = {7'h06, 7'h3F};
      do_reset(3);
      repeat (30) begin
         cur = c;
         tick();
         if (cur == 5) begin
            vectors++; if (seg !== 7'h40) begin miscompares++; $display("FAIL digit0_seg got %h exp 40", seg); end
         end
         if (cur == 15) begin
            vectors++; if (seg !== 7'h79) begin miscompares++; $display("FAIL digit1_seg got %h exp 79", seg); end
         end
         vectors++; if (seg !== e_seg) begin miscompares++; $display("FAIL content_seg c=%0d got %h exp %h", cur, seg, e_seg); end
      end
   endtask

   task automatic test_snapshot();
      enable = 1'b1; blink_sel = 2'd0;
      sec_7seg = 14'($urandom); min_7seg = 14'($urandom); hour_7seg = 14'($urandom);
      do_reset(2);
      repeat (190) begin
         if (c % 60 == 25) min_7seg = ~min_7seg;
         tick();
         vectors++; if (seg !== e_seg) begin miscompares++; $display("FAIL snapshot_seg c=%0d got %h exp %h", c - 1, seg, e_seg); end
         vectors++; if (an !== e_an) begin miscompares++; $display("FAIL snapshot_an c=%0d got %h exp %h", c - 1, an, e_an); end
      end
   endtask

   task automatic test_blink();
      enable = 1'b1; blink_sel = 2'd2;
      sec_7seg = 14'($urandom); min_7seg = 14'($urandom); hour_7seg = 14'($urandom);
      do_reset(2);
      repeat (120) begin
         tick();
         vectors++; if (an !== e_an) begin miscompares++; $display("FAIL blink_an c=%0d got %h exp %h", c - 1, an, e_an); end
         vectors++; if (seg !== e_seg) begin miscompares++; $display("FAIL blink_seg c=%0d got %h exp %h", c - 1, seg, e_seg); end
      end
   endtask

   task automatic test_reset_mid_slot();
      int budget;
      enable = 1'b1; blink_sel = 2'd0; dp_en = 1'b1;
      do_reset(2);
      budget = 0;
      do begin
         tick();
         budget++;
      end while (e_an != 6'b110111 && budget < 60);
      vectors++; if (an !== 6'b110111) begin miscompares++; $display("FAIL pre_mid_reset_an got %h exp 37", an); end
      #2 rst = 1'b1;
      #1;
      vectors++; if (an !== 6'h3F) begin miscompares++; $display("FAIL async_reset_an got %h exp 3f", an); end
      vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL async_reset_seg got %h exp 7f", seg); end
      vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL async_reset_dp got %b exp 1", dp); end
      enable = 1'b0;
      do_reset(3);
      repeat (130) begin
         tick();
         vectors++; if (an !== 6'h3F) begin miscompares++; $display("FAIL disabled_an c=%0d got %h exp 3f", c - 1, an); end
         vectors++; if (frame_tick !== e_ft) begin miscompares++; $display("FAIL disabled_ft c=%0d got %b exp %b", c - 1, frame_tick, e_ft); end
      end
      enable = 1'b1;
   endtask

   task automatic test_dp();
      enable = 1'b1; blink_sel = 2'd0; dp_en = 1'b1;
      do_reset(2);
      repeat (70) begin
         tick();
         vectors++; if (dp !== e_dp) begin miscompares++; $display("FAIL dp c=%0d got %b exp %b", c - 1, dp, e_dp); end
      end
   endtask

   task automatic test_random();
      do_reset(2);
      repeat (700) begin
         if ($urandom_range(0, 15) == 0) enable = 1'($urandom);
         if ($urandom_range(0, 7) == 0) blink_sel = 2'($urandom);
         if ($urandom_range(0, 7) == 0) dp_en = 1'($urandom);
         sec_7seg = 14'($urandom); min_7seg = 14'($urandom); hour_7seg = 14'($urandom);
         tick();
         vectors++; if (an !== e_an) begin miscompares++; $display("FAIL rand_an c=%0d got %h exp %h", c - 1, an, e_an); end
         vectors++; if (seg !== e_seg) begin miscompares++; $display("FAIL rand_seg c=%0d got %h exp %h", c - 1, seg, e_seg); end
         vectors++; if (dp !== e_dp) begin miscompares++; $display("FAIL rand_dp c=%0d got %b exp %b", c - 1, dp, e_dp); end
         vectors++; if (frame_tick !== e_ft) begin miscompares++; $display("FAIL rand_ft c=%0d got %b exp %b", c - 1, frame_tick, e_ft); end
      end
   endtask

   initial begin
      test_reset();
      test_digit_content();
      test_snapshot();
      test_blink();
      test_reset_mid_slot();
      test_dp();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
